// File: rtl/canny_pkg.sv
// Shared definitions for the canny frame sequencer and edge datapath:
// sequencer FSM states and default frame geometry.
package canny_pkg;

    localparam int CANNY_WIDTH  = 640;
    localparam int CANNY_HEIGHT = 512;
    localparam int CANNY_HBLANK = 80;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_LINE,
        ST_HBLANK,
        ST_DRAIN,
        ST_DONE
    } seq_state_t;

    // States in which the issued frame-valid is high
    function automatic logic in_frame(seq_state_t s);
        return (s == ST_LEAD) || (s == ST_LINE) || (s == ST_HBLANK);
    endfunction

endpackage

// File: rtl/canny_seq_timing_pipe.sv
// Two-stage fval/lval alignment pipe; data_in is expected one cycle
// after lval_in (frame RAM latency) and is zeroed outside line-valid.
module canny_seq_timing_pipe #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fval_in,
    input  logic                  lval_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  fval_out,
    output logic                  lval_out,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic fval_q;
    logic lval_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fval_q   <= 1'b0;
            lval_q   <= 1'b0;
            fval_out <= 1'b0;
            lval_out <= 1'b0;
            data_out <= '0;
        end else begin
            fval_q   <= fval_in;
            lval_q   <= lval_in;
            fval_out <= fval_q;
            lval_out <= lval_q;
            data_out <= lval_q ? data_in : '0;
        end
    end

endmodule

// File: rtl/canny_frame_sequencer.sv
// Frame RAM to canny datapath sequencer with line blanking and drain.
// Optional test pattern source enabled by CANNY_SEQ_TPG_EN.
module canny_frame_sequencer
    import canny_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int WIDTH      = CANNY_WIDTH,
    parameter int HEIGHT     = CANNY_HEIGHT,
    parameter int HBLANK     = CANNY_HBLANK,
    parameter int VLEAD      = 1,
    parameter int ADDR_WIDTH = 19
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  en_in,
`ifdef CANNY_SEQ_TPG_EN
    input  logic                  tpg_sel,
`endif
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  b_fval,
    output logic                  b_lval,
    output logic [DATA_WIDTH-1:0] in_data,
    output logic                  en_fun,
    input  logic                  b_fval_sync,
    output logic                  busy,
    output logic                  frame_done,
    output logic [9:0]            line_cnt
);

    localparam int CNT_A   = (WIDTH > HBLANK) ? WIDTH : HBLANK;
    localparam int CNT_MAX = (CNT_A > VLEAD) ? CNT_A : VLEAD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    seq_state_t             state;
    logic [CNT_W-1:0]       cnt;
    logic                   seen_sync;
    logic                   rd_src;
    logic                   last_pix;
    logic [DATA_WIDTH-1:0]  pipe_data;

`ifdef CANNY_SEQ_TPG_EN
    logic                   tpg_mode;
    logic [DATA_WIDTH-1:0]  tpg_q;

    assign rd_src    = ~tpg_mode;
    assign pipe_data = tpg_mode ? tpg_q : mem_rd_data;

    // Delay the pattern one cycle to line up with RAM read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tpg_q <= '0;
        else
            tpg_q <= DATA_WIDTH'(32'(line_cnt) + 32'(cnt));
    end
`else
    assign rd_src    = 1'b1;
    assign pipe_data = mem_rd_data;
`endif

    assign last_pix = (cnt == CNT_W'(WIDTH - 1))
                   && (line_cnt == 10'(HEIGHT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            seen_sync  <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            en_fun     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            line_cnt   <= '0;
`ifdef CANNY_SEQ_TPG_EN
            tpg_mode   <= 1'b0;
`endif
        end else if (abort) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            seen_sync  <= 1'b0;
            mem_rd_en  <= 1'b0;
            en_fun     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            line_cnt   <= '0;
        end else begin
            frame_done <= 1'b0;
            if (busy && b_fval_sync)
                seen_sync <= 1'b1;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_LEAD;
                        busy      <= 1'b1;
                        en_fun    <= en_in;
                        mem_addr  <= '0;
                        cnt       <= '0;
                        line_cnt  <= '0;
                        seen_sync <= 1'b0;
`ifdef CANNY_SEQ_TPG_EN
                        tpg_mode  <= tpg_sel;
`endif
                    end
                end
                ST_LEAD: begin
                    if (cnt == CNT_W'(VLEAD - 1)) begin
                        cnt       <= '0;
                        state     <= ST_LINE;
                        mem_rd_en <= rd_src;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_LINE: begin
                    // Hold on the final pixel so the address never wraps
                    if (!last_pix)
                        mem_addr <= mem_addr + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        cnt       <= '0;
                        state     <= ST_HBLANK;
                        mem_rd_en <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_HBLANK: begin
                    if (cnt == CNT_W'(HBLANK - 1)) begin
                        cnt <= '0;
                        if (line_cnt == 10'(HEIGHT - 1)) begin
                            state <= ST_DRAIN;
                        end else begin
                            line_cnt  <= line_cnt + 1'b1;
                            state     <= ST_LINE;
                            mem_rd_en <= rd_src;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (seen_sync && !b_fval_sync) begin
                        state      <= ST_DONE;
                        frame_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy   <= 1'b0;
                    en_fun <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    canny_seq_timing_pipe #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pipe (
        .clk      (clk),
        .rst      (rst),
        .fval_in  (in_frame(state)),
        .lval_in  (state == ST_LINE),
        .data_in  (pipe_data),
        .fval_out (b_fval),
        .lval_out (b_lval),
        .data_out (in_data)
    );

endmodule
